// File: rtl/result_buffer.sv
`default_nettype none
// ============================================================================
// Module   : result_buffer
// Purpose  : Buffers up to DEPTH detection records {ori_x, ori_y, candidate}
//            in a circular RAM. On request it drains the snapshot of stored
//            records as a serial word stream (x, y, mask per record) under a
//            valid/ready handshake.
// Revision : 1.0  initial release
// ----------------------------------------------------------------------------
// Ports
//   clk            in   system clock, rising edge
//   reset          in   synchronous active-high reset
//   write_in       in   strobe: capture ori_x/ori_y/candidate as one record
//   ori_x, ori_y   in   window origin (DATA_WIDTH)
//   candidate      in   per-scale hit mask (NUM_RESIZE)
//   read_out       in   strobe: start a drain (ignored unless idle)
//   data_ready     in   consumer accepts o_data_out this cycle
//   o_write_in_end out  pulse one cycle after an accepted write
//   o_data_valid   out  o_data_out holds a valid word
//   o_data_out     out  drained word (mask zero-extended)
//   o_field        out  0 = x, 1 = y, 2 = mask
//   o_read_out_end out  pulse: drain complete
//   o_count        out  records currently stored
//   o_overflow     out  sticky: a record was dropped because buffer was full
// Build option
//   RESULT_DEDUP_EN : discard a write identical to the last accepted record
// ============================================================================
module result_buffer #(
  parameter int DATA_WIDTH = 12,
  parameter int NUM_RESIZE = 5,
  parameter int DEPTH      = 64,
  parameter int ADDR_WIDTH = 6
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  write_in,
  input  logic [DATA_WIDTH-1:0] ori_x,
  input  logic [DATA_WIDTH-1:0] ori_y,
  input  logic [NUM_RESIZE-1:0] candidate,
  input  logic                  read_out,
  input  logic                  data_ready,
  output logic                  o_write_in_end,
  output logic                  o_data_valid,
  output logic [DATA_WIDTH-1:0] o_data_out,
  output logic [1:0]            o_field,
  output logic                  o_read_out_end,
  output logic [ADDR_WIDTH:0]   o_count,
  output logic                  o_overflow
);

  localparam int REC_W = 2 * DATA_WIDTH + NUM_RESIZE;
  localparam logic [ADDR_WIDTH:0] FULL_COUNT = (ADDR_WIDTH + 1)'(DEPTH);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_SEND_X = 3'd1,
    S_SEND_Y = 3'd2,
    S_SEND_C = 3'd3,
    S_DONE   = 3'd4
  } state_t;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_WIDTH:0]   count_q, count_d;
  logic [ADDR_WIDTH:0]   remain_q, remain_d;
  logic                  write_end_q, write_end_d;
  logic                  overflow_q, overflow_d;

  logic [REC_W-1:0]      mem_q [DEPTH];
  logic [REC_W-1:0]      rec_in;
  logic [REC_W-1:0]      rd_rec;
  logic                  is_dup;
  logic                  accept;
  logic                  drop;
  logic                  pop;
  logic [DATA_WIDTH-1:0] mask_ext;

  assign rec_in = {ori_x, ori_y, candidate};

`ifdef RESULT_DEDUP_EN
  // Last accepted record; invalid after reset so the first write always lands.
  logic             last_valid_q, last_valid_d;
  logic [REC_W-1:0] last_rec_q, last_rec_d;

  always_comb begin
    is_dup       = last_valid_q && (rec_in == last_rec_q);
    last_valid_d = last_valid_q;
    last_rec_d   = last_rec_q;
    if (accept) begin
      last_valid_d = 1'b1;
      last_rec_d   = rec_in;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      last_valid_q <= 1'b0;
      last_rec_q   <= '0;
    end else begin
      last_valid_q <= last_valid_d;
      last_rec_q   <= last_rec_d;
    end
  end
`else
  always_comb begin
    is_dup = 1'b0;
  end
`endif

  // Full test uses the registered count: a same-cycle pop frees no slot.
  always_comb begin
    accept      = write_in && !is_dup && (count_q != FULL_COUNT);
    drop        = write_in && !is_dup && (count_q == FULL_COUNT);
    wr_ptr_d    = accept ? wr_ptr_q + ADDR_WIDTH'(1) : wr_ptr_q;
    write_end_d = accept;
    overflow_d  = overflow_q | drop;
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      mem_q[wr_ptr_q] <= rec_in;
    end
  end

  // Drain FSM and output decode.
  always_comb begin
    state_d        = state_q;
    remain_d       = remain_q;
    pop            = 1'b0;
    o_data_valid   = 1'b0;
    o_field        = 2'd0;
    o_read_out_end = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (read_out) begin
          remain_d = count_q;
          state_d  = (count_q == '0) ? S_DONE : S_SEND_X;
        end
      end
      S_SEND_X: begin
        o_data_valid = 1'b1;
        o_field      = 2'd0;
        if (data_ready) state_d = S_SEND_Y;
      end
      S_SEND_Y: begin
        o_data_valid = 1'b1;
        o_field      = 2'd1;
        if (data_ready) state_d = S_SEND_C;
      end
      S_SEND_C: begin
        o_data_valid = 1'b1;
        o_field      = 2'd2;
        if (data_ready) begin
          pop      = 1'b1;
          remain_d = remain_q - (ADDR_WIDTH + 1)'(1);
          state_d  = (remain_q == (ADDR_WIDTH + 1)'(1)) ? S_DONE : S_SEND_X;
        end
      end
      S_DONE: begin
        o_read_out_end = 1'b1;
        state_d        = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    rd_ptr_d = pop ? rd_ptr_q + ADDR_WIDTH'(1) : rd_ptr_q;
    count_d  = count_q;
    case ({accept, pop})
      2'b10:   count_d = count_q + (ADDR_WIDTH + 1)'(1);
      2'b01:   count_d = count_q - (ADDR_WIDTH + 1)'(1);
      default: count_d = count_q;
    endcase
  end

  // Only the record under transfer is read; address is the read pointer.
  always_comb begin
    rd_rec                   = mem_q[rd_ptr_q];
    mask_ext                 = '0;
    mask_ext[NUM_RESIZE-1:0] = rd_rec[NUM_RESIZE-1:0];
    case (state_q)
      S_SEND_X: o_data_out = rd_rec[REC_W-1 -: DATA_WIDTH];
      S_SEND_Y: o_data_out = rd_rec[NUM_RESIZE +: DATA_WIDTH];
      S_SEND_C: o_data_out = mask_ext;
      default:  o_data_out = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      remain_q    <= '0;
      write_end_q <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      remain_q    <= remain_d;
      write_end_q <= write_end_d;
      overflow_q  <= overflow_d;
    end
  end

  assign o_write_in_end = write_end_q;
  assign o_count        = count_q;
  assign o_overflow     = overflow_q;

endmodule
`default_nettype wire

// File: tb/tb_result_buffer.sv
`default_nettype none
// ============================================================================
// Module   : tb_result_buffer
// Purpose  : Self-checking bench for result_buffer. Expected drain words are
//            queued when records are written and compared as the DUT hands
//            them over; control outputs are checked against hand-derived
//            values.
// Revision : 1.0  initial release
// ============================================================================
module tb_result_buffer;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        write_in = 1'b0;
  logic [11:0] ori_x = '0;
  logic [11:0] ori_y = '0;
  logic [4:0]  candidate = '0;
  logic        read_out = 1'b0;
  logic        data_ready = 1'b1;
  logic        o_write_in_end;
  logic        o_data_valid;
  logic [11:0] o_data_out;
  logic [1:0]  o_field;
  logic        o_read_out_end;
  logic [6:0]  o_count;
  logic        o_overflow;

  result_buffer #(
    .DATA_WIDTH(12), .NUM_RESIZE(5), .DEPTH(64), .ADDR_WIDTH(6)
  ) dut (
    .clk(clk), .reset(reset), .write_in(write_in), .ori_x(ori_x),
    .ori_y(ori_y), .candidate(candidate), .read_out(read_out),
    .data_ready(data_ready), .o_write_in_end(o_write_in_end),
    .o_data_valid(o_data_valid), .o_data_out(o_data_out), .o_field(o_field),
    .o_read_out_end(o_read_out_end), .o_count(o_count), .o_overflow(o_overflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [11:0] data;
    logic [1:0]  field;
  } exp_t;

  typedef struct {
    logic [11:0] x;
    logic [11:0] y;
    logic [4:0]  c;
    logic [11:0] exp_c;
  } vec_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_pass = 0;
  int   hs_cnt = 0;
  int   valid_cnt = 0;
  bit   hold_pending = 0;
  logic [11:0] held_data;
  logic [1:0]  held_field;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  task automatic push_rec(input logic [11:0] x, input logic [11:0] y,
                          input logic [4:0] c);
    exp_t e;
    e.data = x;              e.field = 2'd0; sb.push_back(e);
    e.data = y;              e.field = 2'd1; sb.push_back(e);
    e.data = {7'b0, c};      e.field = 2'd2; sb.push_back(e);
  endtask

  // Scoreboard monitor: compares every handshaken word, checks hold stability.
  always @(negedge clk) begin
    exp_t e;
    if (!reset) begin
      if (o_data_valid) valid_cnt++;
      if (hold_pending && o_data_valid) begin
        chk("hold_data", o_data_out, held_data);
        chk("hold_field", o_field, held_field);
      end
      hold_pending = o_data_valid && !data_ready;
      held_data    = o_data_out;
      held_field   = o_field;
      if (o_data_valid && data_ready) begin
        hs_cnt++;
        if (sb.size() == 0) chk("extra_word", 1, 0);
        else begin
          e = sb.pop_front();
          chk("word_data", o_data_out, e.data);
          chk("word_field", o_field, e.field);
        end
      end
    end else begin
      hold_pending = 0;
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; write_in = 1'b0; read_out = 1'b0; data_ready = 1'b1;
    sb.delete();
    tick(); tick();
    reset = 1'b0;
  endtask

  task automatic write_rec(input logic [11:0] x, input logic [11:0] y,
                           input logic [4:0] c, output logic ack);
    ori_x = x; ori_y = y; candidate = c; write_in = 1'b1;
    tick();
    write_in = 1'b0;
    @(negedge clk);
    ack = o_write_in_end;
    tick();
  endtask

  // mode 0: ready held high; mode 1: ready pattern 1,0,0,1,0,0,...
  // inject: write two fresh records in cycles 3 and 6 of the drain.
  task automatic drain(input int n_rec, input int mode, input bit inject,
                       output int cyc);
    cyc = -1;
    data_ready = 1'b1;
    read_out = 1'b1;
    tick();
    read_out = 1'b0;
    for (int k = 1; k <= 3 * n_rec * 3 + 40; k++) begin
      @(negedge clk);
      if (o_read_out_end) begin
        cyc = k;
        break;
      end
      tick();
      if (mode == 1) data_ready = (k % 3 == 0);
      write_in = 1'b0;
      if (inject && (k == 2 || k == 5)) begin
        ori_x = 12'h700 + 12'(k); ori_y = 12'(k); candidate = 5'(k);
        write_in = 1'b1;
      end
    end
    if (cyc < 0) chk("drain_timeout", 0, 1);
    tick();
    write_in = 1'b0;
    data_ready = 1'b1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vec_t vecs[4];
    logic ack;
    int   cyc;
    int   vc0;

    vecs[0] = '{12'd10,   12'd20,   5'b00101, 12'd5};
    vecs[1] = '{12'hFFF,  12'h000,  5'b11111, 12'd31};
    vecs[2] = '{12'h000,  12'hABC,  5'b00000, 12'd0};
    vecs[3] = '{12'h123,  12'h456,  5'b10000, 12'd16};

    // Reset state
    do_reset();
    @(negedge clk);
    chk("rst_valid", o_data_valid, 0);
    chk("rst_wend", o_write_in_end, 0);
    chk("rst_rend", o_read_out_end, 0);
    chk("rst_count", o_count, 0);
    chk("rst_ovf", o_overflow, 0);
    chk("rst_data", o_data_out, 0);
    tick();

    // Single record write + drain, table driven
    for (int i = 0; i < 4; i++) begin
      exp_t e;
      write_rec(vecs[i].x, vecs[i].y, vecs[i].c, ack);
      chk("vec_wend", ack, 1);
      @(negedge clk);
      chk("vec_wend_once", o_write_in_end, 0);
      chk("vec_count1", o_count, 1);
      tick();
      e.data = vecs[i].x;     e.field = 2'd0; sb.push_back(e);
      e.data = vecs[i].y;     e.field = 2'd1; sb.push_back(e);
      e.data = vecs[i].exp_c; e.field = 2'd2; sb.push_back(e);
      drain(1, 0, 0, cyc);
      chk("vec_drain_cyc", cyc, 4);
      @(negedge clk);
      chk("vec_count0", o_count, 0);
      tick();
    end

    // Empty drain
    vc0 = valid_cnt;
    drain(0, 0, 0, cyc);
    chk("empty_cyc", cyc, 1);
    chk("empty_no_valid", valid_cnt - vc0, 0);

    // Fill past capacity
    do_reset();
    for (int i = 0; i <= 64; i++) begin
      write_rec(12'(i), 12'(i + 100), 5'(i % 32), ack);
      chk("fill_wend", ack, (i < 64) ? 1 : 0);
    end
    @(negedge clk);
    chk("full_count", o_count, 64);
    chk("full_ovf", o_overflow, 1);
    tick();
    for (int i = 0; i < 64; i++) push_rec(12'(i), 12'(i + 100), 5'(i % 32));
    drain(64, 0, 0, cyc);
    chk("full_drain_cyc", cyc, 193);
    @(negedge clk);
    chk("full_count0", o_count, 0);
    chk("ovf_sticky", o_overflow, 1);
    tick();

    // Ready toggling on a 2-record drain
    write_rec(12'h111, 12'h222, 5'b01010, ack);
    write_rec(12'h333, 12'h444, 5'b10101, ack);
    push_rec(12'h111, 12'h222, 5'b01010);
    push_rec(12'h333, 12'h444, 5'b10101);
    hs_cnt = 0;
    drain(2, 1, 0, cyc);
    chk("toggle_hs", hs_cnt, 6);
    chk("toggle_cyc", cyc, 17);

    // Pointer wrap plus writes during a drain
    do_reset();
    for (int i = 0; i < 62; i++) begin
      write_rec(12'(i * 3), 12'(i * 5), 5'(i), ack);
      push_rec(12'(i * 3), 12'(i * 5), 5'(i));
      drain(1, 0, 0, cyc);
    end
    write_rec(12'h0A1, 12'h0B1, 5'd1, ack);
    write_rec(12'h0A2, 12'h0B2, 5'd2, ack);
    write_rec(12'h0A3, 12'h0B3, 5'd3, ack);
    push_rec(12'h0A1, 12'h0B1, 5'd1);
    push_rec(12'h0A2, 12'h0B2, 5'd2);
    push_rec(12'h0A3, 12'h0B3, 5'd3);
    hs_cnt = 0;
    drain(3, 0, 1, cyc);
    chk("mid_hs", hs_cnt, 9);
    chk("mid_cyc", cyc, 10);
    @(negedge clk);
    chk("mid_count", o_count, 2);
    tick();
    push_rec(12'h702, 12'd2, 5'd2);
    push_rec(12'h705, 12'd5, 5'd5);
    drain(2, 0, 0, cyc);
    chk("mid2_cyc", cyc, 7);
    @(negedge clk);
    chk("mid2_count", o_count, 0);
    tick();

    // Reset during SEND_Y
    write_rec(12'h0CC, 12'h0DD, 5'd7, ack);
    sb.delete();
    begin
      exp_t e;
      e.data = 12'h0CC; e.field = 2'd0; sb.push_back(e);
    end
    data_ready = 1'b1;
    read_out = 1'b1;
    tick();
    read_out = 1'b0;
    tick();
    reset = 1'b1;
    data_ready = 1'b0;
    tick();
    reset = 1'b0;
    @(negedge clk);
    chk("rstmid_valid", o_data_valid, 0);
    chk("rstmid_count", o_count, 0);
    chk("rstmid_rend", o_read_out_end, 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      @(negedge clk);
      chk("rstmid_no_rend", o_read_out_end, 0);
    end
    tick();
    data_ready = 1'b1;

    // Duplicate record handling
    do_reset();
    write_rec(12'h055, 12'h066, 5'd9, ack);
    chk("dup_first_wend", ack, 1);
    write_rec(12'h055, 12'h066, 5'd9, ack);
    @(negedge clk);
`ifdef RESULT_DEDUP_EN
    chk("dup_second_wend", ack, 0);
    chk("dup_count", o_count, 1);
    tick();
    push_rec(12'h055, 12'h066, 5'd9);
    drain(1, 0, 0, cyc);
`else
    chk("dup_second_wend", ack, 1);
    chk("dup_count", o_count, 2);
    tick();
    push_rec(12'h055, 12'h066, 5'd9);
    push_rec(12'h055, 12'h066, 5'd9);
    drain(2, 0, 0, cyc);
`endif
    chk("dup_ovf", o_overflow, 0);
    chk("sb_empty", sb.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
